// File: rtl/gf_serial_mul.sv
// Bit-serial GF(2^M) multiplier in polynomial basis. It processes the multiplier MSB first,
// one bit per clock, and holds the result until the consumer accepts it.
module gf_serial_mul #(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] mul_numA,
  input  logic [M-1:0] mul_numB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] prod,
  output logic         busy
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    a_q, b_q, acc_q;
  logic [CW-1:0]   cnt_q;
  logic [M-1:0]    acc_shift, acc_next;

  // Horner step: multiply the accumulator by x, reduce, then add A if the current B bit is set.
  always_comb begin
    acc_shift = {acc_q[M-2:0], 1'b0} ^ (acc_q[M-1] ? POLY[M-1:0] : '0);
    acc_next  = acc_shift ^ (b_q[cnt_q] ? a_q : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    prod      = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        prod      = acc_q;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the datapath flops are reset too, so a reset mid-operation leaves no stale operands behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= mul_numA;
            b_q   <= mul_numB;
            acc_q <= '0;
            cnt_q <= CW'(M - 1);
          end
        end
        CALC: begin
          acc_q <= acc_next;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_serial_mul.sv
// Self-checking bench for gf_serial_mul. It drives an M=8 instance and an M=4 instance and
// compares them against a carry-less multiply and long-division model.
module tb_gf_serial_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 0, busy8;
  logic [7:0] a8 = 0, b8 = 0, prod8;
  logic       in_valid4 = 0, in_ready4, out_valid4, out_ready4 = 0, busy4;
  logic [3:0] a4 = 0, b4 = 0, prod4;

  gf_serial_mul #(.M(8), .POLY(9'h11D)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .mul_numA(a8), .mul_numB(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .prod(prod8), .busy(busy8)
  );

  gf_serial_mul #(.M(4), .POLY(5'h13)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .mul_numA(a4), .mul_numB(b4), .out_valid(out_valid4), .out_ready(out_ready4),
    .prod(prod4), .busy(busy4)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: carry-less product followed by polynomial long division.
  function automatic int unsigned gf_ref(int unsigned a, int unsigned b, int m, int unsigned poly);
    int unsigned p = 0;
    for (int i = 0; i < m; i++) if (((b >> i) & 1) != 0) p ^= (a << i);
    for (int i = 2 * m - 2; i >= m; i--) if (((p >> i) & 1) != 0) p ^= (poly << (i - m));
    return p;
  endfunction

  // Present one pair to the M=8 instance and wait for out_valid without handing the result off.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
    @(negedge clk);
    in_valid8 = 1'b1; a8 = a; b8 = b; out_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid8 && lat < 40);
    res = prod8;
  endtask

  task automatic release8();
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    check("m8_back_to_idle", {in_ready8, out_valid8, busy8, prod8}, {3'b100, 8'h00});
    out_ready8 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp, input string name);
    int lat;
    @(negedge clk);
    in_valid4 = 1'b1; a4 = a; b4 = b; out_ready4 = 1'b0;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid4 && lat < 40);
    check({name, "_prod"}, prod4, exp);
    check({name, "_lat"}, lat, 4);
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    check({name, "_idle"}, {in_ready4, out_valid4, prod4}, {2'b10, 4'h0});
    out_ready4 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec8_t;

  initial begin
    vec8_t      vecs[7];
    logic [7:0] res, held, ra, rb;
    int         lat, n;
    logic       seen;

    vecs[0] = '{8'h02, 8'h80, 8'h1D};
    vecs[1] = '{8'hFF, 8'h01, 8'hFF};
    vecs[2] = '{8'h00, 8'hA5, 8'h00};
    vecs[3] = '{8'hA5, 8'h00, 8'h00};
    vecs[4] = '{8'h80, 8'h02, 8'h1D};
    vecs[5] = '{8'h02, 8'h02, 8'h04};
    vecs[6] = '{8'h01, 8'h01, 8'h01};

    // Outputs during reset.
    #12;
    check("reset_m8", {in_ready8, out_valid8, busy8, prod8}, {3'b100, 8'h00});
    check("reset_m4", {in_ready4, out_valid4, busy4, prod4}, {3'b100, 4'h0});
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, each also checking the fixed latency.
    for (int i = 0; i < 7; i++) begin
      issue8(vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d_prod", i), res, vecs[i].exp);
      check($sformatf("vec%0d_lat", i), lat, 8);
      release8();
    end

    // Backpressure: the result must stay put while out_ready is low.
    issue8(8'h37, 8'hC4, res, lat);
    held = res;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid8 || in_ready8 || prod8 !== held) seen = 1'b1;
    end
    check("hold_stable", seen, 1'b0);
    check("hold_prod", held, gf_ref(8'h37, 8'hC4, 8, 9'h11D));
    release8();

    // Operands toggle with in_valid high throughout CALC; only the first pair counts.
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'h57; b8 = 8'h83;
    @(posedge clk); #1;
    n = 0;
    seen = 1'b0;
    do begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk); #1;
      n++;
      if (in_ready8) seen = 1'b1;
    end while (!out_valid8 && n < 40);
    in_valid8 = 1'b0;
    check("toggle_no_accept", seen, 1'b0);
    check("toggle_prod", prod8, gf_ref(8'h57, 8'h83, 8, 9'h11D));
    check("toggle_lat", n, 8);
    release8();

    // Reset in mid-CALC aborts the operation asynchronously.
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'h9E; b8 = 8'h6B;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", {in_ready8, out_valid8, busy8, prod8}, {3'b100, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid8 || busy8) seen = 1'b1;
    end
    check("abort_no_result", seen, 1'b0);

    // The first edge after reset release accepts operands.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid8 = 1'b1; a8 = 8'h03; b8 = 8'h07;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("first_edge_accept", busy8, 1'b1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid8 && n < 40);
    check("first_edge_lat", n, 8);
    check("first_edge_prod", prod8, gf_ref(8'h03, 8'h07, 8, 9'h11D));
    release8();

    // Random pairs against the model, M=8.
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom_range(0, 255));
      issue8(ra, rb, res, lat);
      check($sformatf("rand8_%0d", i), {lat[7:0], res}, {8'd8, 8'(gf_ref(ra, rb, 8, 9'h11D))});
      release8();
    end

    // M=4 instance: directed corner cases, then random pairs.
    op4(4'h8, 4'h2, 4'h3, "m4_x3_times_x");
    op4(4'h0, 4'hB, 4'h0, "m4_zero_a");
    op4(4'hD, 4'h1, 4'hD, "m4_one_b");
    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom_range(0, 15));
      rb = 8'($urandom_range(0, 15));
      op4(ra[3:0], rb[3:0], 4'(gf_ref(ra, rb, 4, 5'h13)), $sformatf("rand4_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf_serial_mul.md
GF_SERIAL_MUL -- requirements
Module: gf_serial_mul

Interface
REQ-001 SHALL have parameter M, default 8, meaning the field is GF(2^M); legal range 2..16.
REQ-002 SHALL have parameter POLY, default 9'h11D, meaning the field polynomial in polynomial basis, M+1 bits wide; bit M SHALL be 1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, operand pair present.
REQ-006 SHALL have port in_ready, output, 1 bit, block can accept operands.
REQ-007 SHALL have port mul_numA, input, M bits, multiplicand in polynomial basis.
REQ-008 SHALL have port mul_numB, input, M bits, multiplier in polynomial basis.
REQ-009 SHALL have port out_valid, output, 1 bit, prod holds a finished result.
REQ-010 SHALL have port out_ready, input, 1 bit, consumer accepts the result.
REQ-011 SHALL have port prod, output, M bits, A*B mod POLY in polynomial basis.
REQ-012 SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, latch A and B, clear the accumulator, load bit counter with M-1, and go to CALC.
REQ-015 CALC: each cycle, acc <= (acc*x mod POLY) XOR (B[cnt] ? A : 0), processing B MSB first; shift reduction XORs POLY[M-1:0] when acc[M-1]=1 before the shift.
REQ-016 CALC SHALL last exactly M cycles; after the cycle with cnt=0, go to DONE; counter width is clog2(M).
REQ-017 Latency: if the acceptance edge is edge k, out_valid SHALL rise after edge k+M; latency is fixed and independent of operand values, zeros included.
REQ-018 DONE: out_valid=1 and prod=acc, both held stable until out_valid&out_ready; on that edge, go to IDLE.
REQ-019 in_ready SHALL be 0 in CALC and DONE; operands presented then are ignored, and mul_numA/mul_numB changes after acceptance SHALL NOT affect the result.
REQ-020 The result SHALL be handed off and a new operand accepted on different edges; minimum spacing between acceptances is M+2 cycles with out_ready tied high.
REQ-021 prod SHALL read 0 whenever out_valid=0.
REQ-022 The result SHALL be fully reduced (degree < M); A=0 or B=0 SHALL give 0; B=1 SHALL give A.
REQ-023 in_valid SHALL be sampled only in IDLE; no combinational path from in_valid to in_ready, or from out_ready to out_valid.

Reset
REQ-024 While rst_n=0: state=IDLE, in_ready=1, out_valid=0, busy=0, prod=0, and accumulator, operand registers and counter all 0.
REQ-025 Reset asserted in CALC or DONE SHALL abort the operation immediately; no result SHALL appear after reset is released.
REQ-026 After rst_n deasserts, the first rising edge SHALL be able to accept operands.

Verification
REQ-027 M=8, POLY=9'h11D: A=0x02, B=0x80 accepted at edge k -> out_valid after edge k+8, prod=0x1D.
REQ-028 M=8: A=0xFF, B=0x01 -> prod=0xFF; A=0x00, B=0xA5 -> prod=0x00, still 8-cycle latency.
REQ-029 M=8: out_ready held 0 for 5 cycles in DONE -> out_valid and prod stay constant and in_ready stays 0; out_ready=1 -> IDLE on the next edge.
REQ-030 Operands toggled every cycle during CALC, with in_valid high -> result matches the latched pair and none of the toggled pairs is accepted.
REQ-031 rst_n pulsed low in mid-CALC -> all outputs return to reset values asynchronously and out_valid never asserts for the aborted pair.
REQ-032 M=4, POLY=5'h13: A=0x8, B=0x2 -> prod=0x3 after 4 cycles; random A,B against a reference model for M=8 and M=4.
